// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the divided-clock ratio detector.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam logic [1:0] DIV1 = 2'b00;
  localparam logic [1:0] DIV2 = 2'b01;
  localparam logic [1:0] DIV3 = 2'b10;
  localparam logic [1:0] DIV4 = 2'b11;

  localparam int MIN_P = 2;
  localparam int MAX_P = 4;

  // Divide code is the period minus one; only meaningful for MIN_P..MAX_P.
  function automatic logic [1:0] p2code(input int unsigned p);
    return 2'(p - 1);
  endfunction

endpackage

// File: rtl/clkdiv_edge_sync.sv
// Synchronizes the divided clock into the fast domain and flags its rising edges.
module clkdiv_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic clk_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/clkdiv_ratio_detect.sv
// Measures the period of a divided clock and recovers its divide code, with
// lock, out-of-range and stall reporting.
module clkdiv_ratio_detect
  import clkdiv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 15,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clk_in,
  output logic [1:0]    div_coe,
  output logic [CW-1:0] period,
  output logic          locked,
  output logic          lock_pulse,
  output logic          err_range,
  output logic          stalled
);

  localparam int MW = 3;
  localparam logic [CW-1:0] P_SAT = CW'(TIMEOUT);

  logic rise;

  clkdiv_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .rstn   (rstn),
    .clk_in (clk_in),
    .rise   (rise)
  );

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   last_p_q, last_p_d;
  logic [MW-1:0]   match_q, match_d;
  logic [1:0]      div_coe_q, div_coe_d;
  logic [CW-1:0]   period_q, period_d;
  logic            locked_q, locked_d;
  logic            lock_pulse_q, lock_pulse_d;
  logic            err_q, err_d;
  logic            stalled_q, stalled_d;

  logic            in_range;
  logic [MW-1:0]   match_inc;

  // cnt_q in a rise cycle is the measured period.
  assign in_range  = (cnt_q >= CW'(MIN_P)) && (cnt_q <= CW'(MAX_P));
  assign match_inc = (cnt_q == last_p_q) ? match_q + MW'(1) : MW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ACQ;
      cnt_q        <= '0;
      last_p_q     <= '0;
      match_q      <= '0;
      div_coe_q    <= DIV1;
      period_q     <= '0;
      locked_q     <= 1'b0;
      lock_pulse_q <= 1'b0;
      err_q        <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_p_q     <= last_p_d;
      match_q      <= match_d;
      div_coe_q    <= div_coe_d;
      period_q     <= period_d;
      locked_q     <= locked_d;
      lock_pulse_q <= lock_pulse_d;
      err_q        <= err_d;
      stalled_q    <= stalled_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_p_d     = last_p_q;
    match_d      = match_q;
    div_coe_d    = div_coe_q;
    period_d     = period_q;
    locked_d     = locked_q;
    lock_pulse_d = 1'b0;
    err_d        = 1'b0;
    stalled_d    = stalled_q;

    if (!en) begin
      state_d   = ACQ;
      cnt_d     = '0;
      last_p_d  = '0;
      match_d   = '0;
      div_coe_d = DIV1;
      period_d  = '0;
      locked_d  = 1'b0;
      stalled_d = 1'b0;
    end else if (rise) begin
      // A rise on the saturation cycle still counts; p=TIMEOUT is out of range.
      cnt_d     = CW'(1);
      stalled_d = 1'b0;
      unique case (state_q)
        ACQ: begin
          state_d = MEAS;
          match_d = '0;
        end
        MEAS: begin
          period_d = cnt_q;
          if (in_range) begin
            last_p_d = cnt_q;
            match_d  = match_inc;
            if (match_inc == MW'(LOCK_CNT)) begin
              state_d      = LOCK;
              locked_d     = 1'b1;
              div_coe_d    = p2code(32'(cnt_q));
              lock_pulse_d = 1'b1;
            end
          end else begin
            err_d    = 1'b1;
            match_d  = '0;
            last_p_d = '0;
          end
        end
        LOCK: begin
          period_d = cnt_q;
          if (cnt_q != last_p_q) begin
            state_d  = MEAS;
            locked_d = 1'b0;
            if (in_range) begin
              last_p_d = cnt_q;
              match_d  = MW'(1);
            end else begin
              err_d    = 1'b1;
              match_d  = '0;
              last_p_d = '0;
            end
          end
        end
        default: state_d = ACQ;
      endcase
    end else if (cnt_q == P_SAT) begin
      stalled_d = 1'b1;
      if (state_q != ACQ) begin
        state_d  = ACQ;
        locked_d = 1'b0;
        match_d  = '0;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign div_coe    = div_coe_q;
  assign period     = period_q;
  assign locked     = locked_q;
  assign lock_pulse = lock_pulse_q;
  assign err_range  = err_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_clkdiv_ratio_detect.sv
// Randomized and directed bench for clkdiv_ratio_detect with a queue-based scoreboard.
module tb_clkdiv_ratio_detect;

  localparam int S  = 2;
  localparam int LC = 4;
  localparam int T  = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn, en, clk_in;
  logic [1:0]    div_coe;
  logic [CW-1:0] period;
  logic          locked, lock_pulse, err_range, stalled;

  always #5 clk = ~clk;

  clkdiv_ratio_detect #(
    .SYNC_STAGES(S), .LOCK_CNT(LC), .TIMEOUT(T), .CW(CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .clk_in     (clk_in),
    .div_coe    (div_coe),
    .period     (period),
    .locked     (locked),
    .lock_pulse (lock_pulse),
    .err_range  (err_range),
    .stalled    (stalled)
  );

  typedef struct packed {
    logic [1:0]    coe;
    logic [CW-1:0] per;
    logic          lk;
    logic          lp;
    logic          er;
    logic          st;
  } obs_t;

  obs_t q[$];
  bit   hist[$];          // sampled clk_in values, newest last
  int   cyc_n, ref_c;     // ref_c: cycle at which the measured gap is zero
  int   lastp, nmatch, per;
  bit   armed, lk, st;
  logic [1:0] coe;
  bit   cur_x;
  int   n_cmp, n_err, n_lp, n_er;

  function automatic void model_clear();
    armed = 0; lk = 0; st = 0; coe = 2'b00; per = 0;
    lastp = 0; nmatch = 0; ref_c = cyc_n + 1;
  endfunction

  // One fast-clock edge of the reference behaviour, from the sampled input stream.
  task automatic model_step(input bit x, input bit en_v, input bit rst_v);
    obs_t e;
    int   gap, p;
    bit   rise, lp, er, inr;
    lp = 0; er = 0;
    if (!rst_v) begin
      model_clear();
      hist.delete();
      repeat (S + 1) hist.push_back(1'b0);
    end else begin
      rise = hist[hist.size() - S] && !hist[hist.size() - S - 1];
      hist.push_back(x);
      if (hist.size() > S + 2) void'(hist.pop_front());
      gap = cyc_n - ref_c;
      p   = (gap < T) ? gap : T;
      if (!en_v) begin
        model_clear();
      end else if (rise) begin
        st = 0; ref_c = cyc_n;
        inr = (p >= 2) && (p <= 4);
        if (!armed) begin
          armed = 1; nmatch = 0;
        end else begin
          per = p;
          if (!(lk && p == lastp)) begin
            if (!inr) begin
              er = 1; lk = 0; nmatch = 0; lastp = 0;
            end else if (lk) begin
              lk = 0; lastp = p; nmatch = 1;
            end else begin
              nmatch = (p == lastp) ? nmatch + 1 : 1;
              lastp  = p;
              if (nmatch == LC) begin
                lk = 1; lp = 1; coe = 2'(p - 1);
              end
            end
          end
        end
      end else if (gap >= T) begin
        st = 1;
        if (armed) begin armed = 0; lk = 0; nmatch = 0; end
      end
    end
    e = '{coe, CW'(per), lk, lp, er, st};
    q.push_back(e);
    cyc_n++;
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (lock_pulse) n_lp++;
      if (err_range)  n_er++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{div_coe, period, locked, lock_pulse, err_range, stalled};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs @%0t got coe=%b per=%0d lk=%b lp=%b er=%b st=%b want coe=%b per=%0d lk=%b lp=%b er=%b st=%b",
                   $time, a.coe, a.per, a.lk, a.lp, a.er, a.st, e.coe, e.per, e.lk, e.lp, e.er, e.st);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int all_out();
    return int'({div_coe, period, locked, lock_pulse, err_range, stalled});
  endfunction

  // h1 drives the first half of the cycle, h2 (from the negedge) is what gets sampled.
  task automatic cyc(input bit h1, input bit h2);
    @(posedge clk);
    model_step(cur_x, en, rstn);
    #2 clk_in = h1;
    @(negedge clk);
    #2 clk_in = h2;
    cur_x = h2;
  endtask

  // 50%-duty divide-by-P waveform built from half cycles.
  task automatic run_div(input int P, input int n);
    int ph;
    ph = 0;
    for (int i = 0; i < n; i++) begin
      cyc(ph < P, ((ph + 1) % (2 * P)) < P);
      ph = (ph + 2) % (2 * P);
    end
  endtask

  task automatic run_lvl(input bit h1, input bit h2, input int n);
    for (int i = 0; i < n; i++) cyc(h1, h2);
  endtask

  initial begin : stim
    int r, n;
    n_cmp = 0; n_err = 0; n_lp = 0; n_er = 0;
    cyc_n = 0; cur_x = 0;
    rstn = 1'b0; en = 1'b0; clk_in = 1'b0;
    model_clear();
    repeat (S + 1) hist.push_back(1'b0);
    run_lvl(0, 0, 3);
    rstn = 1'b1;
    chk("reset_outputs", all_out(), 0);

    // /2 from enable
    en = 1'b1; n_lp = 0; n_er = 0;
    run_div(2, 15);
    chk("div2_locked", int'(locked), 1);
    chk("div2_coe", int'(div_coe), 1);
    chk("div2_period", int'(period), 2);
    chk("div2_lock_pulses", n_lp, 1);
    chk("div2_err_pulses", n_er, 0);

    run_div(3, 30);
    chk("div3_coe", int'(div_coe), 2);
    chk("div3_period", int'(period), 3);
    run_div(4, 30);
    chk("div4_coe", int'(div_coe), 3);
    chk("div4_period", int'(period), 4);

    // ratio change while locked
    run_div(2, 20);
    n_lp = 0;
    run_div(4, 24);
    chk("change_locked", int'(locked), 1);
    chk("change_coe", int'(div_coe), 3);
    chk("change_lock_pulses", n_lp, 1);

    // one period of 5 while locked at /3
    run_div(3, 21);
    n_er = 0;
    run_div(5, 5);
    run_div(3, 20);
    chk("oor_err_pulses", n_er, 1);
    chk("oor_relock", int'(locked), 1);
    chk("oor_coe", int'(div_coe), 2);

    // stall, then undivided input
    run_lvl(0, 0, 20);
    chk("stall_stalled", int'(stalled), 1);
    chk("stall_locked", int'(locked), 0);
    run_lvl(1, 0, 20);
    chk("div1_stalled", int'(stalled), 1);

    // reset in MEAS
    run_div(4, 10);
    rstn = 1'b0;
    #1 chk("async_reset_outputs", all_out(), 0);
    run_div(4, 3);
    rstn = 1'b1;

    // enable drop while locked
    run_div(2, 20);
    chk("pre_en_locked", int'(locked), 1);
    n_lp = 0;
    en = 1'b0;
    run_div(2, 3);
    chk("en_low_outputs", all_out(), 0);
    en = 1'b1;
    run_div(2, 20);
    chk("reen_locked", int'(locked), 1);
    chk("reen_lock_pulses", n_lp, 1);

    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 9));
      n = int'($urandom_range(3, 40));
      if (r <= 5) run_div(int'($urandom_range(2, 6)), n);
      else if (r == 6) begin
        for (int i = 0; i < n; i++) cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end else if (r == 7) begin
        case ($urandom_range(0, 2))
          0:       run_lvl(0, 0, n);
          1:       run_lvl(1, 1, n);
          default: run_lvl(1, 0, n);
        endcase
      end else if (r == 8) begin
        en = 1'b0;
        run_div(2, int'($urandom_range(1, 4)));
        en = 1'b1;
      end else begin
        rstn = 1'b0;
        #1 chk("rand_reset_outputs", all_out(), 0);
        run_lvl(0, 0, 2);
        rstn = 1'b1;
      end
    end

    run_lvl(0, 0, 3);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
